// File: rtl/llsc_mem_ctrl.sv
// llsc_mem_ctrl
// MEM-stage controller that executes LL (load-linked) and SC (store-conditional)
// against a simple request/acknowledge data bus.
//
// Ports:
//   clk, Rst_n            clock, synchronous active-low reset
//   flush                 abort the current operation (exception/eret)
//   op_valid/op_ll/op_sc  MEM stage presents an LL or SC
//   op_addr, op_wdata     effective address and SC store data
//   LLbit_i               LLbit register output
//   wb_LLbit_we/_value    LLbit write pending in WB (bypassed into the SC decision)
//   snoop_valid/_addr     external store observed; kills a matching link
//   bus_req/we/addr/wdata request side of the data bus
//   bus_rdata/bus_ack     response side of the data bus
//   stall_req             hold the pipeline while a bus access is outstanding
//   result_valid/_data    one-cycle result pulse (LL: loaded word, SC: 1/0)
//   LLbit_we_o/_value_o   one-cycle LLbit register write
//   addr_err_o            one-cycle pulse for a misaligned address
//
// Bus handshake: bus_req is a request held high, together with stable bus_we,
// bus_addr and bus_wdata, until the cycle in which bus_ack is sampled high; the
// transfer completes in that cycle and bus_req drops on the following edge.
// bus_ack outside an outstanding request is ignored. A request dropped by flush
// or reset is simply abandoned.
module llsc_mem_ctrl #(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int LINK_LSB = 2
) (
  input  logic              clk,
  input  logic              Rst_n,
  input  logic              flush,
  input  logic              op_valid,
  input  logic              op_ll,
  input  logic              op_sc,
  input  logic [ADDR_W-1:0] op_addr,
  input  logic [DATA_W-1:0] op_wdata,
  input  logic              LLbit_i,
  input  logic              wb_LLbit_we,
  input  logic              wb_LLbit_value,
  input  logic              snoop_valid,
  input  logic [ADDR_W-1:0] snoop_addr,
  output logic              bus_req,
  output logic              bus_we,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_wdata,
  input  logic [DATA_W-1:0] bus_rdata,
  input  logic              bus_ack,
  output logic              stall_req,
  output logic              result_valid,
  output logic [DATA_W-1:0] result_data,
  output logic              LLbit_we_o,
  output logic              LLbit_value_o,
  output logic              addr_err_o
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUS  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]        state_q, state_d;
  logic              bus_req_q, bus_req_d;
  logic              bus_we_q, bus_we_d;
  logic [ADDR_W-1:0] bus_addr_q, bus_addr_d;
  logic [DATA_W-1:0] bus_wdata_q, bus_wdata_d;
  logic              stall_req_q, stall_req_d;
  logic              result_valid_q, result_valid_d;
  logic [DATA_W-1:0] result_data_q, result_data_d;
  logic              llbit_we_q, llbit_we_d;
  logic              llbit_value_q, llbit_value_d;
  logic              addr_err_q, addr_err_d;
  logic [ADDR_W-1:0] link_addr_q, link_addr_d;
  logic              link_valid_q, link_valid_d;

  logic eff_llbit;
  logic link_match;
  logic snoop_hit;

  always_comb begin
    state_d        = state_q;
    bus_req_d      = bus_req_q;
    bus_we_d       = bus_we_q;
    bus_addr_d     = bus_addr_q;
    bus_wdata_d    = bus_wdata_q;
    stall_req_d    = stall_req_q;
    result_valid_d = 1'b0;
    result_data_d  = result_data_q;
    llbit_we_d     = 1'b0;
    llbit_value_d  = llbit_value_q;
    addr_err_d     = 1'b0;
    link_addr_d    = link_addr_q;
    link_valid_d   = link_valid_q;

    // A WB-stage LLbit write in flight is newer than the register output.
    eff_llbit  = wb_LLbit_we ? wb_LLbit_value : LLbit_i;
    link_match = (op_addr[ADDR_W-1:LINK_LSB] == link_addr_q[ADDR_W-1:LINK_LSB]);

    case (state_q)
      ST_IDLE: begin
        if (op_valid && (op_ll || op_sc)) begin
          if (op_addr[1:0] != 2'b00) begin
            addr_err_d = 1'b1;
          end else if (op_ll) begin
            state_d     = ST_BUS;
            bus_req_d   = 1'b1;
            bus_we_d    = 1'b0;
            bus_addr_d  = op_addr;
            stall_req_d = 1'b1;
          end else if (eff_llbit && link_valid_q && link_match) begin
            state_d     = ST_BUS;
            bus_req_d   = 1'b1;
            bus_we_d    = 1'b1;
            bus_addr_d  = op_addr;
            bus_wdata_d = op_wdata;
            stall_req_d = 1'b1;
          end else begin
            // Failed SC: the store is suppressed, only the 0 result is returned.
            state_d        = ST_DONE;
            result_valid_d = 1'b1;
            result_data_d  = '0;
          end
        end
      end
      ST_BUS: begin
        if (bus_ack) begin
          state_d        = ST_DONE;
          bus_req_d      = 1'b0;
          stall_req_d    = 1'b0;
          result_valid_d = 1'b1;
          llbit_we_d     = 1'b1;
          if (!bus_we_q) begin
            // bus_addr_q still holds the address latched at LL acceptance.
            result_data_d = bus_rdata;
            llbit_value_d = 1'b1;
            link_addr_d   = bus_addr_q;
            link_valid_d  = 1'b1;
          end else begin
            result_data_d = {{(DATA_W-1){1'b0}}, 1'b1};
            llbit_value_d = 1'b0;
            link_valid_d  = 1'b0;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Compared against the updated link address so a snoop that hits an LL
    // completing this cycle is ordered after the load and kills the new link.
    snoop_hit = snoop_valid &&
                (snoop_addr[ADDR_W-1:LINK_LSB] == link_addr_d[ADDR_W-1:LINK_LSB]);
    if (snoop_hit) begin
      link_valid_d = 1'b0;
    end

    // Flush overrides everything, including a bus_ack arriving this cycle.
    if (flush) begin
      state_d        = ST_IDLE;
      bus_req_d      = 1'b0;
      stall_req_d    = 1'b0;
      result_valid_d = 1'b0;
      result_data_d  = result_data_q;
      llbit_we_d     = 1'b0;
      llbit_value_d  = llbit_value_q;
      addr_err_d     = 1'b0;
      link_addr_d    = link_addr_q;
      link_valid_d   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!Rst_n) begin
      state_q        <= ST_IDLE;
      bus_req_q      <= 1'b0;
      bus_we_q       <= 1'b0;
      bus_addr_q     <= '0;
      bus_wdata_q    <= '0;
      stall_req_q    <= 1'b0;
      result_valid_q <= 1'b0;
      result_data_q  <= '0;
      llbit_we_q     <= 1'b0;
      llbit_value_q  <= 1'b0;
      addr_err_q     <= 1'b0;
      link_addr_q    <= '0;
      link_valid_q   <= 1'b0;
    end else begin
      state_q        <= state_d;
      bus_req_q      <= bus_req_d;
      bus_we_q       <= bus_we_d;
      bus_addr_q     <= bus_addr_d;
      bus_wdata_q    <= bus_wdata_d;
      stall_req_q    <= stall_req_d;
      result_valid_q <= result_valid_d;
      result_data_q  <= result_data_d;
      llbit_we_q     <= llbit_we_d;
      llbit_value_q  <= llbit_value_d;
      addr_err_q     <= addr_err_d;
      link_addr_q    <= link_addr_d;
      link_valid_q   <= link_valid_d;
    end
  end

  assign bus_req       = bus_req_q;
  assign bus_we        = bus_we_q;
  assign bus_addr      = bus_addr_q;
  assign bus_wdata     = bus_wdata_q;
  assign stall_req     = stall_req_q;
  assign result_valid  = result_valid_q;
  assign result_data   = result_data_q;
  assign LLbit_we_o    = llbit_we_q;
  assign LLbit_value_o = llbit_value_q;
  assign addr_err_o    = addr_err_q;

endmodule

// File: doc/llsc_mem_ctrl.md
Name: llsc_mem_ctrl

Overview:
- MEM-stage controller that executes LL and SC instructions against the data bus.
- Reads the LLbit register value, bypassing any pending WB-stage LLbit write, and keeps a private link address and link-valid flag.
- Decides SC success or failure, runs the bus transaction, and emits the LLbit write and the rt writeback value.
- Stalls the pipeline while a bus access is outstanding.

Parameters:
ADDR_W, 32, bus address width
DATA_W, 32, bus data width
LINK_LSB, 2, low address bits ignored in link-address compare (word granularity)

Ports:
clk  in  1  clock
Rst_n  in  1  synchronous, active-low reset
flush  in  1  pipeline flush (exception/eret); abort current op
op_valid  in  1  MEM stage holds a valid LL or SC
op_ll  in  1  op is LL
op_sc  in  1  op is SC (op_ll and op_sc never both 1)
op_addr  in  ADDR_W  effective address
op_wdata  in  DATA_W  SC store data
LLbit_i  in  1  current LLbit register output
wb_LLbit_we  in  1  WB stage writing LLbit this cycle
wb_LLbit_value  in  1  value WB stage writes
snoop_valid  in  1  external store observed
snoop_addr  in  ADDR_W  address of external store
bus_req  out  1  bus request
bus_we  out  1  1 = write (SC), 0 = read (LL)
bus_addr  out  ADDR_W  bus address
bus_wdata  out  DATA_W  bus write data
bus_rdata  in  DATA_W  bus read data
bus_ack  in  1  transfer complete, one-cycle pulse
stall_req  out  1  hold the pipeline
result_valid  out  1  one-cycle pulse; result_data valid
result_data  out  DATA_W  LL: loaded word; SC: 1 on success, 0 on failure
LLbit_we_o  out  1  write LLbit register (one-cycle pulse)
LLbit_value_o  out  1  LLbit value to write
addr_err_o  out  1  one-cycle pulse on misaligned address

Behaviour:
- Reset (Rst_n=0 at a clk edge):
  - State goes to IDLE.
  - All outputs go to 0.
  - link_addr goes to 0 and link_valid goes to 0.
- States: IDLE, BUS, DONE. All outputs are registered.
- Effective LLbit: eff = wb_LLbit_we ? wb_LLbit_value : LLbit_i.
- Link match: op_addr[ADDR_W-1:LINK_LSB] == link_addr[ADDR_W-1:LINK_LSB].
- IDLE, op_valid=1:
  - Misaligned (op_addr[1:0]!=0): next cycle addr_err_o=1, no bus request, no LLbit write; stay IDLE.
  - LL: latch the address, then bus_req=1, bus_we=0, bus_addr=op_addr, stall_req=1; go to BUS.
  - SC with eff=1, link_valid=1 and link match: bus_req=1, bus_we=1, bus_wdata=op_wdata, stall_req=1; go to BUS.
  - SC otherwise (failure): go to DONE with result_data=0 and LLbit_we_o=0. No bus cycle; the store is suppressed.
- BUS:
  - bus_req, bus_we, bus_addr and bus_wdata stay stable and stall_req stays 1 until bus_ack.
  - On bus_ack: drop bus_req and stall_req next cycle; go to DONE.
  - LL completion: result_data=bus_rdata, LLbit_we_o=1, LLbit_value_o=1, link_addr<=latched address, link_valid<=1.
  - SC completion: result_data=1, LLbit_we_o=1, LLbit_value_o=0, link_valid<=0.
- DONE: result_valid=1 for exactly one cycle, then IDLE. op_valid is ignored in DONE.
- Latency:
  - LL/SC success: result_valid is 1 cycle after the bus_ack cycle.
  - SC failure: result_valid is 1 cycle after acceptance.
- Snoop: snoop_valid=1 and snoop_addr word matches link_addr -> link_valid<=0.
  - Snoop does not write the LLbit register.
  - Snoop matching the address of an LL completing in the same cycle -> link_valid ends 0; the store is ordered after the load.
- Flush (highest priority after reset):
  - Any state goes to IDLE next cycle.
  - bus_req, stall_req, result_valid and LLbit_we_o go to 0.
  - A bus_ack in the flush cycle is discarded: no LLbit write, link state unchanged.
  - link_valid is cleared on flush.
  - The bus slave tolerates an abandoned request.
- Reset mid-transaction: same abort as flush; bus_req drops on the reset edge.
- bus_ack while in IDLE or DONE: ignored.

Test Plan:
- LL to 0x100, ack after 3 cycles with rdata 0xDEADBEEF -> stall_req high 4 cycles; then result_valid=1, result_data=0xDEADBEEF, LLbit_we_o=1, LLbit_value_o=1.
- LL 0x100, then SC 0x100 with data 0x55 and LLbit_i=1 -> bus write to 0x100 with wdata 0x55; result_data=1, LLbit_we_o=1, LLbit_value_o=0.
- LL 0x100, snoop_valid with snoop_addr 0x102, then SC 0x100 -> no bus_req; result_data=0 one cycle after acceptance; LLbit_we_o=0.
- SC 0x100 with LLbit_i=0 but wb_LLbit_we=1, wb_LLbit_value=1 after a valid LL 0x100 -> bypass applies; SC succeeds.
- LL in BUS, flush asserted in the same cycle as bus_ack -> next cycle IDLE, result_valid=0, LLbit_we_o=0; a following SC 0x100 fails.
- SC to 0x101 -> addr_err_o pulse; no bus_req, no result_valid.
